// File: rtl/gray_pixel_packer.sv
// gray_pixel_packer: tracks grey results in flight, saturates them to bytes
// and packs four per word into a show-ahead FIFO. Option: GRAY_PIXEL_PACKER_SAT_COUNT_EN
module gray_pixel_packer #(
   parameter int LATENCY    = 10,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   input  logic [31:0] Y,
   output logic [31:0] out_data,
   output logic [3:0]  out_keep,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overflow
`ifdef GRAY_PIXEL_PACKER_SAT_COUNT_EN
   ,
   output logic [15:0] sat_count
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(LATENCY + 1);

   logic [LATENCY-1:0] dl_q, dl_d;
   logic [IW-1:0]      infl_q, infl_d;
   logic [1:0]         pcnt_q, pcnt_d;
   logic [23:0]        pack_q, pack_d;
   logic               flp_q, flp_d;
   logic               ovf_q, ovf_d;
   logic [31:0]        mem_q [FIFO_DEPTH];
   logic [3:0]         keep_q [FIFO_DEPTH];
   logic [AW-1:0]      wp_q, rp_q;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic        accept, capture, clip, pop, full, push, wr;
   logic [7:0]  sat_b;
   logic [31:0] push_data, room, need;
   logic [3:0]  push_keep;

   assign capture   = dl_q[LATENCY-1];
   assign clip      = Y[31] | (|Y[30:8]);
   assign sat_b     = Y[31] ? 8'h00 : ((|Y[30:8]) ? 8'hFF : Y[7:0]);
   assign room      = (32'(FIFO_DEPTH) - 32'(cnt_q)) << 2;
   assign need      = 32'(infl_q) + 32'(pcnt_q);
   assign in_ready  = (room > need) && !flp_q;
   assign accept    = in_valid && in_ready;
   assign out_valid = (cnt_q != '0);
   assign full      = (cnt_q == CW'(FIFO_DEPTH));
   assign pop       = out_valid && out_ready;
   assign wr        = push && (!full || pop);
   assign out_data  = out_valid ? mem_q[rp_q] : 32'h0;
   assign out_keep  = out_valid ? keep_q[rp_q] : 4'h0;
   assign overflow  = ovf_q;

   // next state: delay line, in-flight count, packer, flush and FIFO count
   always_comb begin
      dl_d      = '0;
      infl_d    = infl_q;
      pcnt_d    = pcnt_q;
      pack_d    = pack_q;
      flp_d     = flp_q;
      push      = 1'b0;
      push_data = 32'h0;
      push_keep = 4'h0;
      cnt_d     = cnt_q;
      dl_d[0] = accept;
      for (int i = 1; i < LATENCY; i++) dl_d[i] = dl_q[i-1];
      if (accept && !capture) infl_d = infl_q + 1'b1;
      else if (!accept && capture) infl_d = infl_q - 1'b1;
      if (capture) begin
         pcnt_d = pcnt_q + 2'd1;
         case (pcnt_q)
            2'd0: pack_d[7:0]   = sat_b;
            2'd1: pack_d[15:8]  = sat_b;
            2'd2: pack_d[23:16] = sat_b;
            default: begin
               push      = 1'b1;
               push_data = {sat_b, pack_q};
               push_keep = 4'hF;
               pack_d    = '0;
            end
         endcase
      end else if (flp_q && infl_q == '0) begin
         flp_d  = 1'b0;
         pcnt_d = 2'd0;
         pack_d = '0;
         if (pcnt_q != 2'd0) begin
            push      = 1'b1;
            push_data = {8'h00, pack_q};
            case (pcnt_q)
               2'd1:    push_keep = 4'b0001;
               2'd2:    push_keep = 4'b0011;
               default: push_keep = 4'b0111;
            endcase
         end
      end
      if (flush && !flp_q) flp_d = 1'b1;
      case ({wr, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      ovf_d = ovf_q | (in_valid & ~in_ready) | (push & full & ~pop);
   end

   // tracking, packing and sticky error state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_q   <= '0;
         infl_q <= '0;
         pcnt_q <= '0;
         pack_q <= '0;
         flp_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         dl_q   <= dl_d;
         infl_q <= infl_d;
         pcnt_q <= pcnt_d;
         pack_q <= pack_d;
         flp_q  <= flp_d;
         ovf_q  <= ovf_d;
      end
   end

   // output FIFO storage and pointers; pointers wrap by natural overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i]  <= '0;
            keep_q[i] <= '0;
         end
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr) begin
            mem_q[wp_q]  <= push_data;
            keep_q[wp_q] <= push_keep;
            wp_q         <= wp_q + 1'b1;
         end
         if (pop) rp_q <= rp_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

`ifdef GRAY_PIXEL_PACKER_SAT_COUNT_EN
   logic [15:0] sat_q;
   assign sat_count = sat_q;

   // count clipped captures, holding at the top value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sat_q <= '0;
      else if (capture && clip && sat_q != 16'hFFFF) sat_q <= sat_q + 16'd1;
   end
`endif

endmodule

// File: tb/tb_gray_pixel_packer.sv
// Bench for gray_pixel_packer: vector table, corner sequences and
// randomized traffic against a byte-queue reference model.
module tb_gray_pixel_packer;

   localparam int L = 10;
   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush;
   logic        out_valid, out_ready, overflow;
   logic [31:0] Y, out_data;
   logic [3:0]  out_keep;
`ifdef GRAY_PIXEL_PACKER_SAT_COUNT_EN
   logic [15:0] sat_count;
`endif

   always #5 clk = ~clk;

   gray_pixel_packer #(.LATENCY(L), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .Y(Y), .out_data(out_data), .out_keep(out_keep),
      .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
`ifdef GRAY_PIXEL_PACKER_SAT_COUNT_EN
      , .sat_count(sat_count)
`endif
   );

   typedef struct { logic [31:0] d; logic [3:0] k; } wd_t;
   typedef struct { int y[4]; int n; logic [31:0] w; logic [3:0] k; } vec_t;

   int nerr = 0, nchk = 0, cyc = 0, npop = 0, nacc = 0, msat = 0;
   int last_pop_cyc = 0;
   logic [31:0] last_d;
   logic [3:0]  last_k;
   bit force_v = 0;
   int sched [int];
   int pend [$];
   wd_t exp_q [$];
   vec_t tbl [6];

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      nchk++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   function automatic int satv(input int v);
      if (v < 0) return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   task automatic emit();
      wd_t w;
      w.d = 0;
      for (int i = 0; i < pend.size(); i++) w.d = w.d + (32'(pend[i]) << (8 * i));
      w.k = 4'((1 << pend.size()) - 1);
      exp_q.push_back(w);
      pend.delete();
   endtask

   task automatic mpush(input int v);
      if ((v < 0 || v > 255) && msat < 65535) msat++;
      pend.push_back(satv(v));
      if (pend.size() == 4) emit();
   endtask

   task automatic mflush();
      if (pend.size() > 0) emit();
   endtask

   function automatic int rand_y();
      case ($urandom % 4)
         0: return int'($urandom % 256);
         1: return -int'($urandom % 1000) - 1;
         2: return 256 + int'($urandom % 100000);
         default: return int'($urandom);
      endcase
   endfunction

   task automatic tick(input bit want, input bit fl, input bit ordy, input int yv);
      bit acc;
      wd_t w;
      out_ready = ordy;
      flush = fl;
      Y = sched.exists(cyc) ? sched[cyc] : $urandom;
      #1;
      in_valid = want && (in_ready || force_v);
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         npop++;
         last_pop_cyc = cyc;
         last_d = out_data;
         last_k = out_keep;
         nchk++;
         if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_word: got %h keep %h expected none", out_data, out_keep);
         end else begin
            w = exp_q.pop_front();
            if (out_data !== w.d || out_keep !== w.k) begin
               nerr++;
               $display("FAIL word_order: got %h/%h expected %h/%h", out_data, out_keep, w.d, w.k);
            end
         end
      end
      @(posedge clk);
      if (acc) begin
         sched[cyc + L] = yv;
         mpush(yv);
         nacc++;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic setv(input int i, input int a, input int b, input int c, input int d,
                       input int n, input logic [31:0] w, input logic [3:0] k);
      tbl[i].y[0] = a; tbl[i].y[1] = b; tbl[i].y[2] = c; tbl[i].y[3] = d;
      tbl[i].n = n; tbl[i].w = w; tbl[i].k = k;
   endtask

   initial begin
      int a0, p0, ic;
      setv(0, 10, 20, 30, 40, 4, 32'h281E140A, 4'hF);
      setv(1, -5, 256, 255, 32'h7FFFFFFF, 4, 32'hFFFFFF00, 4'hF);
      setv(2, 1, 2, 0, 0, 2, 32'h00000201, 4'b0011);
      setv(3, 0, 255, 128, -1, 4, 32'h0080FF00, 4'hF);
      setv(4, 300, -100, 3, 0, 3, 32'h000300FF, 4'b0111);
      setv(5, 77, 0, 0, 0, 1, 32'h0000004D, 4'b0001);

      rst = 1; in_valid = 0; flush = 0; out_ready = 0; Y = 0;
      @(negedge clk); @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_keep", out_keep, 0);
      chk("rst_overflow", overflow, 0);
      rst = 0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);

      for (int i = 0; i < 6; i++) begin
         p0 = npop;
         a0 = nacc;
         ic = 0;
         for (int j = 0; j < tbl[i].n; j++) begin
            ic = cyc;
            tick(1, 0, 1, tbl[i].y[j]);
         end
         chk("vec_accepted", nacc - a0, tbl[i].n);
         if (tbl[i].n < 4) begin
            tick(0, 1, 1, 0);
            mflush();
            chk("flush_in_ready_low", in_ready, 0);
         end
         for (int t = 0; t < L + 12 && npop == p0; t++) tick(0, 0, 1, 0);
         chk("vec_pop_count", npop - p0, 1);
         chk("vec_data", last_d, tbl[i].w);
         chk("vec_keep", last_k, tbl[i].k);
         if (tbl[i].n == 4) chk("vec_latency", last_pop_cyc, ic + L + 1);
`ifdef GRAY_PIXEL_PACKER_SAT_COUNT_EN
         chk("vec_sat_count", sat_count, msat);
`endif
      end

      a0 = nacc;
      for (int t = 0; t < 80; t++) tick(1, 0, 0, rand_y());
      chk("bp_accepted", nacc - a0, 4 * D);
      chk("bp_full_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_overflow", overflow, 0);
      force_v = 1;
      tick(1, 0, 0, 0);
      force_v = 0;
      chk("ovf_set", overflow, 1);
      p0 = npop;
      for (int t = 0; t < 12; t++) tick(0, 0, 1, 0);
      chk("bp_drained", npop - p0, D);
      chk("ovf_sticky", overflow, 1);
      chk("bp_empty", out_valid, 0);

      for (int t = 0; t < 8; t++) tick(1, 0, 0, rand_y());
      for (int t = 0; t < L + 2; t++) tick(0, 0, 0, 0);
      for (int t = 0; t < 3; t++) tick(1, 0, 0, rand_y());
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      chk("pre_rst_valid", out_valid, 1);
      #3 rst = 1;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_data", out_data, 0);
      chk("async_rst_overflow", overflow, 0);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      rst = 0;
      exp_q.delete();
      pend.delete();
      msat = 0;
      for (int t = 0; t < L + 4; t++) tick(0, 0, 1, 0);
      chk("post_rst_quiet", out_valid, 0);
      p0 = npop;
      for (int j = 5; j <= 8; j++) tick(1, 0, 1, j);
      for (int t = 0; t < L + 6 && npop == p0; t++) tick(0, 0, 1, 0);
      chk("post_rst_pop", npop - p0, 1);
      chk("post_rst_lane0", last_d, 32'h08070605);
      chk("post_rst_keep", last_k, 4'hF);

      for (int t = 0; t < 800; t++) begin
         if ($urandom % 50 == 0) begin
            tick(0, 1, ($urandom % 3) != 0, 0);
            mflush();
            for (int k = 0; k < L + 3; k++) tick(0, 0, ($urandom % 3) != 0, 0);
         end else begin
            tick(($urandom % 4) != 0, 0, ($urandom % 3) != 0, rand_y());
         end
      end
      tick(0, 1, 1, 0);
      mflush();
      for (int t = 0; t < L + D + 8; t++) tick(0, 0, 1, 0);
      chk("rand_all_popped", exp_q.size(), 0);
      chk("rand_empty", out_valid, 0);
      chk("rand_overflow", overflow, 0);
`ifdef GRAY_PIXEL_PACKER_SAT_COUNT_EN
      chk("rand_sat_count", sat_count, msat);
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
